// File: rtl/muldiv.sv
// muldiv: iterative MIPS mult/multu/div/divu unit holding the HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, done_q, done_d;
  logic sa, sb;
  logic [WIDTH-1:0] ma, mb, quot, rem;
  logic [WIDTH:0] sum, shifted, trial;
  logic [2*WIDTH-1:0] prod;
  // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    sa = ~op[0] & srca[WIDTH-1];
    sb = ~op[0] & srcb[WIDTH-1];
    ma = sa ? -srca : srca;
    mb = sb ? -srcb : srcb;
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shifted = acc_q[2*WIDTH-1:WIDTH-1];
    trial = shifted - {1'b0, opnd_q};
    prod = neg_lo_q ? -acc_q : acc_q;
    quot = (opnd_q == '0) ? '1 : neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opnd_d = opnd_q;
    hi_d = hi_q;
    lo_d = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d = state_q == FIX;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          opnd_d = op[1] ? mb : ma;
          acc_d = {{WIDTH{1'b0}}, op[1] ? ma : mb};
          neg_lo_d = sa ^ sb;
          neg_hi_d = op[1] & sa;
          cnt_d = '0;
          state_d = RUN;
        end else begin
          hi_d = mthi ? srca : hi_q;
          lo_d = mtlo ? srca : lo_q;
        end
      end
      RUN: begin
        acc_d = op_q[1] ? {trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0],
                           acc_q[WIDTH-2:0], ~trial[WIDTH]}
                        : {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'(WIDTH-1)) ? FIX : RUN;
      end
      FIX: begin
        hi_d = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d = op_q[1] ? quot : prod[WIDTH-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      opnd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opnd_q <= opnd_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
